// File: rtl/fft_seq_ctrl.sv
// fft_seq_ctrl: in-place FFT sequencer for the four-bank BRAM / single-PE datapath.
// Generates read/write bank addresses, write strobe, twiddle ROM address, crossbar
// selects and PE bypass for each of the LOG2N-1 stages of an N-point transform.
// Optional feature: define FFT_SEQ_CTRL_ABORT_EN to add the 'abort' input, which
// returns a running sequence to idle on the next edge without raising done.
module fft_seq_ctrl #(
    parameter int LOG2N = 8,
    parameter int LAT   = 2
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             start,
    input  logic             inverse,
`ifdef FFT_SEQ_CTRL_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic [3:0]       stage,
    output logic [LOG2N-3:0] rd_addr0,
    output logic [LOG2N-3:0] rd_addr1,
    output logic [LOG2N-3:0] wr_addr0,
    output logic [LOG2N-3:0] wr_addr1,
    output logic             wr_en,
    output logic [LOG2N-1:0] tf_addr,
    output logic             tf_conj,
    output logic             in_swap,
    output logic             out_swap,
    output logic             bypass_n
);

    localparam int AW     = LOG2N - 2;
    localparam int DEPTH  = 1 << AW;
    localparam int NSTAGE = AW + 1;
    localparam int CW     = AW + 1;

    localparam logic [CW-1:0] CYC_LAST   = CW'(DEPTH + LAT - 1);
    localparam logic [CW-1:0] CYC_LAT    = CW'(LAT);
    localparam logic [3:0]    STAGE_LAST = 4'(NSTAGE - 1);
    localparam logic [3:0]    STAGE_BYP  = 4'(AW);
    localparam logic [3:0]    SH_TOP     = 4'(AW);
    localparam logic [3:0]    SH_OSW     = 4'(AW - 1);
    localparam logic [AW-1:0] ONES       = '1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [3:0]    stage_q, stage_d;
    logic          inv_q, inv_d;
    logic          done_q, done_d;
    logic          abort_i;

    logic          run;
    logic [AW-1:0] rd_cnt, wr_cnt;
    logic [AW-1:0] hi_mask, lo_mask;
    logic [AW-1:0] sh_rd, sh_wr, tf_x;
    logic [LOG2N-1:0] tf_x_ext;
    logic          top_nz;

`ifdef FFT_SEQ_CTRL_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    // State, counters, latched direction and done flag; synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            stage_q <= '0;
            inv_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            stage_q <= stage_d;
            inv_q   <= inv_d;
            done_q  <= done_d;
        end
    end

    // Next-state: accept start only while idle, step cyc/stage while running.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        stage_d = stage_q;
        inv_d   = inv_q;
        done_d  = done_q;
        case (state_q)
            IDLE: begin
                if (start && !abort_i) begin
                    state_d = RUN;
                    cyc_d   = '0;
                    stage_d = '0;
                    inv_d   = inverse;
                    done_d  = 1'b0;
                end
            end
            RUN: begin
                if (abort_i) begin
                    state_d = IDLE;
                    cyc_d   = '0;
                    stage_d = '0;
                end else if (cyc_q == CYC_LAST) begin
                    cyc_d = '0;
                    if (stage_q == STAGE_LAST) begin
                        state_d = IDLE;
                        stage_d = '0;
                        done_d  = 1'b1;
                    end else begin
                        stage_d = stage_q + 4'd1;
                    end
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Address, strobe and select generation, combinational from the registered counters.
    always_comb begin
        run      = (state_q == RUN);
        rd_cnt   = cyc_q[AW-1:0];
        wr_cnt   = AW'(cyc_q - CYC_LAT);
        lo_mask  = ONES >> stage_q;
        hi_mask  = ~lo_mask;
        top_nz   = (rd_cnt & hi_mask) != '0;
        // Bit AW-s of rd_cnt and bit AW-1-s of wr_cnt, brought down to bit 0.
        sh_rd    = rd_cnt >> (SH_TOP - stage_q);
        sh_wr    = wr_cnt >> (SH_OSW - stage_q);
        tf_x     = rd_cnt & lo_mask;
        tf_x_ext = LOG2N'(tf_x);

        busy     = run;
        done     = done_q;
        stage    = stage_q;
        tf_conj  = inv_q;
        bypass_n = (stage_q != STAGE_BYP);
        rd_addr0 = '0;
        rd_addr1 = '0;
        wr_addr0 = '0;
        wr_addr1 = '0;
        wr_en    = 1'b0;
        in_swap  = 1'b0;
        out_swap = 1'b0;
        tf_addr  = '0;

        if (run) begin
            rd_addr0 = rd_cnt;
            rd_addr1 = rd_cnt ^ hi_mask;
            wr_addr0 = wr_cnt;
            wr_addr1 = wr_cnt ^ hi_mask;
            wr_en    = (cyc_q >= CYC_LAT);
            in_swap  = (stage_q != 4'd0) && top_nz && sh_rd[0];
            out_swap = (stage_q < STAGE_BYP) && sh_wr[0];
            if (stage_q == 4'd0) begin
                tf_addr = LOG2N'(rd_cnt);
            end else if (stage_q < STAGE_BYP) begin
                tf_addr = top_nz ? (tf_x_ext << (stage_q + 4'd1)) : (tf_x_ext << stage_q);
            end
        end
    end

endmodule
